// File: rtl/alu_cmd_sequencer_pkg.sv
// Shared types and encodings for the ALU command sequencer.
package alu_seq_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    ISSUE = 2'b01,
    WAIT  = 2'b10,
    RESP  = 2'b11
  } seq_state_t;

  localparam logic [1:0] CLS_ARITH = 2'b00;
  localparam logic [1:0] CLS_LOGIC = 2'b01;
  localparam logic [1:0] CLS_CMP   = 2'b10;
  localparam logic [1:0] CLS_SHIFT = 2'b11;

  // alu_flags is packed {Arith, Logic, CMP, SHIFT}, so the class order is reversed.
  function automatic logic [1:0] flag_index(input logic [1:0] cls);
    return 2'd3 - cls;
  endfunction

endpackage

// File: rtl/alu_cmd_sequencer_if.sv
// Request, ALU and response signals of the sequencer; slave is the sequencer, master the host/ALU side.
interface alu_cmd_sequencer_if
  import alu_seq_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int CNT_W = 16
);

  logic                 req_valid;
  logic                 req_ready;
  logic [WIDTH-1:0]     req_a;
  logic [WIDTH-1:0]     req_b;
  logic [3:0]           req_fun;

  logic [WIDTH-1:0]     alu_a;
  logic [WIDTH-1:0]     alu_b;
  logic [3:0]           alu_fun;
  logic [2*WIDTH-1:0]   alu_arith;
  logic [WIDTH-1:0]     alu_logic;
  logic [WIDTH-1:0]     alu_shift;
  logic [1:0]           alu_cmp;
  logic                 alu_carry;
  logic [3:0]           alu_flags;

  logic                 rsp_valid;
  logic                 rsp_ready;
  logic [2*WIDTH-1:0]   rsp_data;
  logic                 rsp_carry;
  logic                 rsp_err;
  logic [CNT_W-1:0]     ops_done;

  modport slave (
    input  req_valid, req_a, req_b, req_fun,
    input  alu_arith, alu_logic, alu_shift, alu_cmp, alu_carry, alu_flags,
    input  rsp_ready,
    output req_ready,
    output alu_a, alu_b, alu_fun,
    output rsp_valid, rsp_data, rsp_carry, rsp_err, ops_done
  );

  modport master (
    output req_valid, req_a, req_b, req_fun,
    output alu_arith, alu_logic, alu_shift, alu_cmp, alu_carry, alu_flags,
    output rsp_ready,
    input  req_ready,
    input  alu_a, alu_b, alu_fun,
    input  rsp_valid, rsp_data, rsp_carry, rsp_err, ops_done
  );

endinterface

// File: rtl/alu_cmd_sequencer_result_mux.sv
// Picks the result, carry and expected unit flag for the class in ALU_FUN[3:2].
module alu_result_mux
  import alu_seq_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic [1:0]         cls,
  input  logic [2*WIDTH-1:0] arith,
  input  logic [WIDTH-1:0]   logic_out,
  input  logic [WIDTH-1:0]   shift_out,
  input  logic [1:0]         cmp_out,
  input  logic               carry,
  input  logic [3:0]         flags,
  output logic [2*WIDTH-1:0] data,
  output logic               carry_sel,
  output logic               flag_sel
);

  // Zero-extend the narrow unit outputs; carry only has meaning for arith.
  always_comb begin
    data      = {(2*WIDTH){1'b0}};
    carry_sel = 1'b0;
    flag_sel  = flags[flag_index(cls)];
    case (cls)
      CLS_ARITH: begin
        data      = arith;
        carry_sel = carry;
      end
      CLS_LOGIC: data = {{WIDTH{1'b0}}, logic_out};
      CLS_CMP:   data = {{(2*WIDTH-2){1'b0}}, cmp_out};
      CLS_SHIFT: data = {{WIDTH{1'b0}}, shift_out};
      default: begin
        data      = {(2*WIDTH){1'b0}};
        carry_sel = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/alu_cmd_sequencer.sv
// One-op-in-flight initiator for the hierarchical ALU: accept, issue, wait out the ALU
// latency, capture the class-selected result and hold it until the consumer takes it.
module alu_cmd_sequencer
  import alu_seq_pkg::*;
#(
  parameter int WIDTH   = 16,
  parameter int ALU_LAT = 1,
  parameter int CNT_W   = 16
) (
  input  logic               clk,
  input  logic               reset_n,
  alu_cmd_sequencer_if.slave bus
);

  localparam int                WAIT_W    = (ALU_LAT > 1) ? $clog2(ALU_LAT) : 1;
  localparam logic [WAIT_W-1:0] WAIT_LOAD = WAIT_W'(ALU_LAT - 1);
  localparam logic [WAIT_W-1:0] WAIT_ZERO = {WAIT_W{1'b0}};
  localparam logic [WAIT_W-1:0] WAIT_ONE  = {{(WAIT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0]  OPS_MAX   = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0]  OPS_ONE   = {{(CNT_W-1){1'b0}}, 1'b1};

  seq_state_t         state_r;
  logic               req_ready_r;
  logic [WIDTH-1:0]   alu_a_r;
  logic [WIDTH-1:0]   alu_b_r;
  logic [3:0]         alu_fun_r;
  logic [WAIT_W-1:0]  wait_cnt_r;
  logic               rsp_valid_r;
  logic [2*WIDTH-1:0] rsp_data_r;
  logic               rsp_carry_r;
  logic               rsp_err_r;
  logic [CNT_W-1:0]   ops_done_r;

  logic [2*WIDTH-1:0] sel_data_s;
  logic               sel_carry_s;
  logic               sel_flag_s;

  alu_result_mux #(.WIDTH(WIDTH)) u_result_mux (
    .cls       (alu_fun_r[3:2]),
    .arith     (bus.alu_arith),
    .logic_out (bus.alu_logic),
    .shift_out (bus.alu_shift),
    .cmp_out   (bus.alu_cmp),
    .carry     (bus.alu_carry),
    .flags     (bus.alu_flags),
    .data      (sel_data_s),
    .carry_sel (sel_carry_s),
    .flag_sel  (sel_flag_s)
  );

  // Sequencer FSM; every output is a register, alu_* change only on an accept.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_r     <= IDLE;
      req_ready_r <= 1'b0;
      alu_a_r     <= {WIDTH{1'b0}};
      alu_b_r     <= {WIDTH{1'b0}};
      alu_fun_r   <= 4'b0000;
      wait_cnt_r  <= WAIT_ZERO;
      rsp_valid_r <= 1'b0;
      rsp_data_r  <= {(2*WIDTH){1'b0}};
      rsp_carry_r <= 1'b0;
      rsp_err_r   <= 1'b0;
      ops_done_r  <= {CNT_W{1'b0}};
    end else begin
      case (state_r)
        IDLE: begin
          if (bus.req_valid && req_ready_r) begin
            alu_a_r     <= bus.req_a;
            alu_b_r     <= bus.req_b;
            alu_fun_r   <= bus.req_fun;
            req_ready_r <= 1'b0;
            state_r     <= ISSUE;
          end else begin
            req_ready_r <= 1'b1;
          end
        end
        ISSUE: begin
          wait_cnt_r <= WAIT_LOAD;
          state_r    <= WAIT;
        end
        WAIT: begin
          if (wait_cnt_r == WAIT_ZERO) begin
            rsp_data_r  <= sel_data_s;
            rsp_carry_r <= sel_carry_s;
            rsp_err_r   <= ~sel_flag_s;
            rsp_valid_r <= 1'b1;
            state_r     <= RESP;
          end else begin
            wait_cnt_r <= wait_cnt_r - WAIT_ONE;
          end
        end
        RESP: begin
          // Ready rises only on the way back to IDLE, so nothing is accepted in this cycle.
          if (bus.rsp_ready) begin
            rsp_valid_r <= 1'b0;
            req_ready_r <= 1'b1;
            state_r     <= IDLE;
            if (ops_done_r != OPS_MAX) begin
              ops_done_r <= ops_done_r + OPS_ONE;
            end else begin
              ops_done_r <= OPS_MAX;
            end
          end else begin
            rsp_valid_r <= 1'b1;
          end
        end
        default: begin
          state_r     <= IDLE;
          req_ready_r <= 1'b0;
          rsp_valid_r <= 1'b0;
        end
      endcase
    end
  end

  assign bus.req_ready = req_ready_r;
  assign bus.alu_a     = alu_a_r;
  assign bus.alu_b     = alu_b_r;
  assign bus.alu_fun   = alu_fun_r;
  assign bus.rsp_valid = rsp_valid_r;
  assign bus.rsp_data  = rsp_data_r;
  assign bus.rsp_carry = rsp_carry_r;
  assign bus.rsp_err   = rsp_err_r;
  assign bus.ops_done  = ops_done_r;

endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// Self-checking bench for alu_cmd_sequencer with a 1-clock registered ALU model
// and a reference model built from the result-class and flag rules.
module tb_alu_cmd_sequencer;

  localparam int WIDTH   = 16;
  localparam int ALU_LAT = 1;
  localparam int CNT_W   = 4;  // small so the saturating counter is reachable
  localparam int OPS_SAT = (1 << CNT_W) - 1;

  logic clk     = 1'b0;
  logic reset_n = 1'b0;

  int checks    = 0;
  int errors    = 0;
  int model_ops = 0;

  logic [15:0] stim_logic = 16'h0000;
  logic [15:0] stim_shift = 16'h0000;
  logic [1:0]  stim_cmp   = 2'b00;
  logic        stim_carry = 1'b0;
  logic [3:0]  stim_flags = 4'b1111;

  alu_cmd_sequencer_if #(.WIDTH(WIDTH), .CNT_W(CNT_W)) bus ();

  alu_cmd_sequencer #(.WIDTH(WIDTH), .ALU_LAT(ALU_LAT), .CNT_W(CNT_W)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  // ALU model: arith is a real add of the issued operands, the others come from stim_*.
  always @(posedge clk) begin
    bus.alu_arith <= {16'h0000, bus.alu_a} + {16'h0000, bus.alu_b};
    bus.alu_logic <= stim_logic;
    bus.alu_shift <= stim_shift;
    bus.alu_cmp   <= stim_cmp;
    bus.alu_carry <= stim_carry;
    bus.alu_flags <= stim_flags;
  end

  initial begin
    bus.req_valid = 1'b0;
    bus.req_a     = 16'h0000;
    bus.req_b     = 16'h0000;
    bus.req_fun   = 4'b0000;
    bus.rsp_ready = 1'b0;
  end

  function automatic logic [31:0] ref_data(input logic [3:0] fun, input logic [15:0] a, input logic [15:0] b);
    int unit = int'(fun[3:2]);
    if (unit == 0) return {16'h0000, a} + {16'h0000, b};
    else if (unit == 1) return {16'h0000, stim_logic};
    else if (unit == 2) return {30'h0, stim_cmp};
    else return {16'h0000, stim_shift};
  endfunction

  function automatic logic ref_err(input logic [3:0] fun);
    int unit = int'(fun[3:2]);
    return ~stim_flags[3 - unit];
  endfunction

  function automatic logic ref_carry(input logic [3:0] fun);
    return (fun[3:2] == 2'b00) ? stim_carry : 1'b0;
  endfunction

  function automatic int sat_ops(input int n);
    return (n > OPS_SAT) ? OPS_SAT : n;
  endfunction

  // Drivers only; every comparison is made in the scenario tasks.
  task automatic send_req(input logic [15:0] a, input logic [15:0] b, input logic [3:0] fun, output bit ok);
    ok = 1'b0;
    bus.req_a = a; bus.req_b = b; bus.req_fun = fun; bus.req_valid = 1'b1;
    for (int i = 0; i < 16; i++) begin
      if (bus.req_ready) begin ok = 1'b1; break; end
      @(negedge clk);
    end
    @(negedge clk);
    bus.req_valid = 1'b0;
  endtask

  task automatic wait_rsp(output int lat);
    lat = 1;
    while (!bus.rsp_valid && lat < 20) begin
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic finish_rsp();
    bus.rsp_ready = 1'b1;
    @(negedge clk);
    bus.rsp_ready = 1'b0;
    model_ops++;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    repeat (2) @(negedge clk);
    checks++; if (bus.rsp_valid !== 1'b0) begin errors++; $display("FAIL reset_rsp_valid: got %b want 0", bus.rsp_valid); end
    checks++; if (bus.req_ready !== 1'b0) begin errors++; $display("FAIL reset_req_ready: got %b want 0", bus.req_ready); end
    checks++; if (bus.ops_done !== 4'h0) begin errors++; $display("FAIL reset_ops_done: got %h want 0", bus.ops_done); end
    checks++; if (bus.alu_fun !== 4'h0 || bus.alu_a !== 16'h0) begin errors++; $display("FAIL reset_alu: got fun %h a %h want 0 0", bus.alu_fun, bus.alu_a); end
    checks++; if (bus.rsp_data !== 32'h0) begin errors++; $display("FAIL reset_rsp_data: got %h want 0", bus.rsp_data); end
    reset_n = 1'b1;
    @(negedge clk);
    checks++; if (bus.req_ready !== 1'b1) begin errors++; $display("FAIL release_req_ready: got %b want 1", bus.req_ready); end
    model_ops = 0;
  endtask

  task automatic test_directed();
    for (int i = 0; i < 3; i++) begin
      logic [15:0] a, b;
      logic [3:0]  fun;
      logic [31:0] exp_d;
      logic        exp_e;
      bit          ok;
      int          lat;
      case (i)
        0: begin a = 16'h0003; b = 16'h0004; fun = 4'b0000; stim_flags = 4'b1000; stim_carry = 1'b0;
                 exp_d = 32'h0000_0007; exp_e = 1'b0; end
        1: begin a = 16'($urandom); b = 16'($urandom); fun = 4'b0110; stim_logic = 16'hFFF0;
                 stim_flags = 4'b0100; stim_carry = 1'b1; exp_d = 32'h0000_FFF0; exp_e = 1'b0; end
        default: begin a = 16'($urandom); b = 16'($urandom); fun = 4'b1001; stim_cmp = 2'b10;
                 stim_flags = 4'b1101; stim_carry = 1'b1; exp_d = 32'h0000_0002; exp_e = 1'b1; end
      endcase
      send_req(a, b, fun, ok);
      checks++; if (!ok) begin errors++; $display("FAIL dir%0d_accept: got no accept want accept", i); end
      checks++; if (bus.alu_a !== a || bus.alu_b !== b || bus.alu_fun !== fun) begin errors++;
        $display("FAIL dir%0d_issue: got %h %h %h want %h %h %h", i, bus.alu_a, bus.alu_b, bus.alu_fun, a, b, fun); end
      wait_rsp(lat);
      checks++; if (lat !== 3) begin errors++; $display("FAIL dir%0d_latency: got %0d want 3", i, lat); end
      checks++; if (bus.rsp_data !== exp_d) begin errors++; $display("FAIL dir%0d_data: got %h want %h", i, bus.rsp_data, exp_d); end
      checks++; if (bus.rsp_err !== exp_e) begin errors++; $display("FAIL dir%0d_err: got %b want %b", i, bus.rsp_err, exp_e); end
      checks++; if (bus.rsp_carry !== 1'b0) begin errors++; $display("FAIL dir%0d_carry: got %b want 0", i, bus.rsp_carry); end
      finish_rsp();
      checks++; if (int'(bus.ops_done) !== sat_ops(model_ops)) begin errors++;
        $display("FAIL dir%0d_ops_done: got %0d want %0d", i, bus.ops_done, sat_ops(model_ops)); end
    end
  endtask

  task automatic test_backpressure();
    logic [15:0] a = 16'h1234, b = 16'h00FF;
    logic [3:0]  fun = 4'b1110;
    logic [31:0] exp_d = 32'h0000_A5A5;
    bit ok;
    int lat, stable_bad = 0, ready_bad = 0;
    stim_shift = 16'hA5A5; stim_flags = 4'b0001; stim_carry = 1'b1;
    send_req(a, b, fun, ok);
    checks++; if (!ok) begin errors++; $display("FAIL bp_accept: got no accept want accept"); end
    wait_rsp(lat);
    checks++; if (lat !== 3) begin errors++; $display("FAIL bp_latency: got %0d want 3", lat); end
    for (int c = 0; c < 5; c++) begin
      bus.req_valid = (c % 2 == 0);
      bus.req_a = 16'($urandom); bus.req_b = 16'($urandom); bus.req_fun = 4'($urandom);
      if (bus.rsp_valid !== 1'b1 || bus.rsp_data !== exp_d || bus.rsp_err !== 1'b0 || bus.rsp_carry !== 1'b0) stable_bad++;
      if (bus.req_ready !== 1'b0) ready_bad++;
      @(negedge clk);
    end
    checks++; if (stable_bad != 0) begin errors++; $display("FAIL bp_stable: got %0d unstable cycles want 0", stable_bad); end
    checks++; if (ready_bad != 0) begin errors++; $display("FAIL bp_req_ready: got %0d ready cycles want 0", ready_bad); end
    bus.req_valid = 1'b1; bus.req_a = ~a; bus.req_fun = 4'b0000;
    finish_rsp();
    checks++; if (bus.rsp_valid !== 1'b0 || bus.req_ready !== 1'b1) begin errors++;
      $display("FAIL bp_handshake: got valid %b ready %b want 0 1", bus.rsp_valid, bus.req_ready); end
    checks++; if (bus.alu_a !== a || bus.alu_fun !== fun) begin errors++;
      $display("FAIL bp_no_latch: got a %h fun %h want %h %h", bus.alu_a, bus.alu_fun, a, fun); end
    bus.req_valid = 1'b0;
    checks++; if (int'(bus.ops_done) !== sat_ops(model_ops)) begin errors++;
      $display("FAIL bp_ops_done: got %0d want %0d", bus.ops_done, sat_ops(model_ops)); end
  endtask

  task automatic test_reset_mid();
    bit ok;
    int lat, seen = 0;
    logic [15:0] a = 16'h0101, b = 16'h0202;
    send_req(a, b, 4'b0011, ok);
    @(negedge clk);
    reset_n = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    model_ops = 0;
    for (int c = 0; c < 6; c++) begin
      if (bus.rsp_valid !== 1'b0) seen++;
      @(negedge clk);
    end
    checks++; if (seen != 0) begin errors++; $display("FAIL mid_reset_no_rsp: got %0d valid cycles want 0", seen); end
    checks++; if (bus.ops_done !== 4'h0) begin errors++; $display("FAIL mid_reset_ops: got %0d want 0", bus.ops_done); end
    stim_flags = 4'b1111; stim_carry = 1'b1;
    send_req(a, b, 4'b0001, ok);
    wait_rsp(lat);
    checks++; if (!ok || lat !== 3 || bus.rsp_data !== 32'h0000_0303 || bus.rsp_carry !== 1'b1) begin errors++;
      $display("FAIL mid_reset_next: got ok %b lat %0d data %h carry %b want 1 3 00000303 1", ok, lat, bus.rsp_data, bus.rsp_carry); end
    finish_rsp();
    checks++; if (int'(bus.ops_done) !== 1) begin errors++; $display("FAIL mid_reset_count: got %0d want 1", bus.ops_done); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] exp_d_q[$];
    logic        exp_e_q[$];
    int          acc_q[$];
    int          sent = 0, got = 0;
    bit          renew = 1'b1;
    logic [31:0] want_d;
    logic        want_e;
    stim_logic = 16'($urandom); stim_shift = 16'($urandom); stim_cmp = 2'($urandom); stim_flags = 4'($urandom);
    bus.rsp_ready = 1'b1;
    for (int cyc = 0; cyc < 60 && got < 4; cyc++) begin
      if (renew) begin
        if (sent < 4) begin
          bus.req_a = 16'($urandom); bus.req_b = 16'($urandom); bus.req_fun = 4'($urandom); bus.req_valid = 1'b1;
        end else begin
          bus.req_valid = 1'b0;
        end
        renew = 1'b0;
      end
      if (bus.rsp_valid) begin
        want_d = (exp_d_q.size() > 0) ? exp_d_q.pop_front() : 32'hDEAD_BEEF;
        want_e = (exp_e_q.size() > 0) ? exp_e_q.pop_front() : 1'b0;
        checks++; if (bus.rsp_data !== want_d || bus.rsp_err !== want_e) begin errors++;
          $display("FAIL b2b_rsp%0d: got %h err %b want %h err %b", got, bus.rsp_data, bus.rsp_err, want_d, want_e); end
        got++;
        model_ops++;
      end
      if (bus.req_valid && bus.req_ready) begin
        exp_d_q.push_back(ref_data(bus.req_fun, bus.req_a, bus.req_b));
        exp_e_q.push_back(ref_err(bus.req_fun));
        acc_q.push_back(cyc);
        sent++;
        renew = 1'b1;
      end
      @(negedge clk);
    end
    bus.rsp_ready = 1'b0;
    bus.req_valid = 1'b0;
    checks++; if (got != 4) begin errors++; $display("FAIL b2b_count: got %0d responses want 4", got); end
    for (int i = 1; i < acc_q.size(); i++) begin
      checks++; if (acc_q[i] - acc_q[i-1] != 4) begin errors++;
        $display("FAIL b2b_interval%0d: got %0d clocks want 4", i, acc_q[i] - acc_q[i-1]); end
    end
    checks++; if (int'(bus.ops_done) !== sat_ops(model_ops)) begin errors++;
      $display("FAIL b2b_ops_done: got %0d want %0d", bus.ops_done, sat_ops(model_ops)); end
  endtask

  task automatic test_random();
    for (int n = 0; n < 20; n++) begin
      logic [15:0] a = 16'($urandom), b = 16'($urandom);
      logic [3:0]  fun = 4'($urandom);
      bit ok;
      int lat;
      stim_logic = 16'($urandom); stim_shift = 16'($urandom); stim_cmp = 2'($urandom);
      stim_carry = 1'($urandom); stim_flags = 4'($urandom);
      send_req(a, b, fun, ok);
      checks++; if (!ok || bus.alu_a !== a || bus.alu_b !== b || bus.alu_fun !== fun) begin errors++;
        $display("FAIL rnd%0d_issue: got ok %b %h %h %h want 1 %h %h %h", n, ok, bus.alu_a, bus.alu_b, bus.alu_fun, a, b, fun); end
      wait_rsp(lat);
      checks++; if (lat !== 3) begin errors++; $display("FAIL rnd%0d_latency: got %0d want 3", n, lat); end
      repeat ($urandom_range(0, 3)) @(negedge clk);
      checks++; if (bus.rsp_valid !== 1'b1 || bus.rsp_data !== ref_data(fun, a, b) ||
                    bus.rsp_err !== ref_err(fun) || bus.rsp_carry !== ref_carry(fun)) begin errors++;
        $display("FAIL rnd%0d_rsp: got v %b %h err %b c %b want 1 %h err %b c %b", n, bus.rsp_valid, bus.rsp_data,
                 bus.rsp_err, bus.rsp_carry, ref_data(fun, a, b), ref_err(fun), ref_carry(fun)); end
      finish_rsp();
      checks++; if (int'(bus.ops_done) !== sat_ops(model_ops)) begin errors++;
        $display("FAIL rnd%0d_ops_done: got %0d want %0d", n, bus.ops_done, sat_ops(model_ops)); end
    end
    checks++; if (bus.ops_done !== 4'hF) begin errors++; $display("FAIL ops_saturated: got %h want f", bus.ops_done); end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_backpressure();
    test_reset_mid();
    test_back_to_back();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
